// File: rtl/alu_sequencer.sv
// Multi-cycle ALU control sequencer: decodes an instruction class/function code, then steps
// IDLE -> LOAD -> (SHIFT x shamt) -> DONE. Optional abort input under macro ALU_SEQ_ABORT_EN.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] alu_op,
  input  logic [4:0] funccode,
  input  logic [4:0] shamt,
`ifdef ALU_SEQ_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       load_en,
  output logic       step_en,
  output logic [2:0] res_op,
  output logic       cin,
  output logic       dir,
  output logic       done
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned OP_W  = 3;

  localparam logic [1:0] ALU_R = 2'b01;
  localparam logic [1:0] ALU_I = 2'b10;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_COMP = 3'b001;
  localparam logic [OP_W-1:0] OP_AND  = 3'b010;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b100;
  localparam logic [OP_W-1:0] OP_SHA  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t            state, state_next;
  logic              accept;
  logic [CNT_W-1:0]  cnt;
  logic              shift_q;
  logic [OP_W-1:0]   dec_op;
  logic              dec_dir;
  logic              dec_shift;

  // Instruction decode; only consumed on the accepting edge.
  always_comb begin
    dec_op    = OP_ADD;
    dec_dir   = 1'b0;
    dec_shift = 1'b0;
    case (alu_op)
      ALU_I: if (funccode == 5'b00001) dec_op = OP_COMP;
      ALU_R: begin
        case (funccode)
          5'b00001: dec_op = OP_COMP;
          5'b00010: dec_op = OP_AND;
          5'b00011: dec_op = OP_XOR;
          5'b00100, 5'b00101: begin dec_op = OP_SHL; dec_shift = 1'b1; end
          5'b00110, 5'b00111: begin dec_op = OP_SHL; dec_dir = 1'b1; dec_shift = 1'b1; end
          5'b01000, 5'b01001: begin dec_op = OP_SHA; dec_shift = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state logic; abort (when built in) overrides everything except DONE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE:  if (start) begin state_next = S_LOAD; accept = 1'b1; end
      S_LOAD:  state_next = (shift_q && cnt != '0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (cnt == CNT_W'(1)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
`ifdef ALU_SEQ_ABORT_EN
    if (abort && state != S_DONE) begin
      state_next = S_IDLE;
      accept     = 1'b0;
    end
`endif
  end

  // Registered outputs track the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= 1'b0;
      load_en <= 1'b0;
      step_en <= 1'b0;
      done    <= 1'b0;
      res_op  <= OP_ADD;
      cin     <= 1'b0;
      dir     <= 1'b0;
      shift_q <= 1'b0;
      cnt     <= '0;
    end else begin
      busy    <= (state_next != S_IDLE);
      load_en <= (state_next == S_LOAD);
      step_en <= (state_next == S_SHIFT);
      done    <= (state_next == S_DONE);
      if (accept) begin
        res_op  <= dec_op;
        cin     <= 1'b0;
        dir     <= dec_dir;
        shift_q <= dec_shift;
        cnt     <= shamt;
      end else if (state == S_SHIFT) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port start, input, 1, operation request; sampled only in IDLE.
REQ-004 SHALL have port alu_op, input, 2, instruction class: 00 DEF, 01 R, 10 I, 11 LS.
REQ-005 SHALL have port funccode, input, 5, function code.
REQ-006 SHALL have port shamt, input, 5, shift amount, 0..31.
REQ-007 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-008 SHALL have port load_en, output, 1, datapath latches operands into accumulator.
REQ-009 SHALL have port step_en, output, 1, datapath performs one 1-bit shift of accumulator.
REQ-010 SHALL have port res_op, output, 3, result select: ADD 000, COMP 001, AND 010, XOR 011, SHIFT_L 100, SHIFT_A 101.
REQ-011 SHALL have ports cin and dir, output, 1 each, adder carry-in and shift direction (0 left, 1 right).
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse; also the register-file write strobe.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE.
REQ-014 SHALL, in IDLE with start=1 at an edge, register decoded res_op/cin/dir, load 5-bit counter with shamt, and go to LOAD.
REQ-015 SHALL decode: LS, DEF -> ADD; I: 00000 ADD, 00001 COMP, else ADD; R: 00000 ADD, 00001 COMP, 00010 AND, 00011 XOR, 00100/00101 SHIFT_L dir=0, 00110/00111 SHIFT_L dir=1, 01000/01001 SHIFT_A dir=0, else ADD; cin=0 in all cases.
REQ-016 SHALL classify funccode 00100..01001 under R as shift ops; all others are non-shift.
REQ-017 SHALL assert load_en only in LOAD.
REQ-018 SHALL go LOAD -> SHIFT when shift op and counter nonzero, else LOAD -> DONE.
REQ-019 SHALL assert step_en every SHIFT cycle, decrement counter each SHIFT cycle, and go SHIFT -> DONE in the cycle counter equals 1.
REQ-020 SHALL assert done only in DONE and then return to IDLE unconditionally.
REQ-021 SHALL give latency: start at edge k -> done high in cycle k+2 for non-shift or shamt=0; in cycle k+2+shamt for shift ops (max k+33).
REQ-022 SHALL hold res_op/cin/dir constant from LOAD through DONE; inputs changing mid-operation have no effect.
REQ-023 SHALL ignore start while busy=1; no queuing; start high in the DONE cycle is ignored, start high in the following IDLE cycle is accepted.
REQ-024 SHALL keep load_en, step_en, done mutually exclusive.

Reset
REQ-025 SHALL on rst=0 immediately force state IDLE, counter 0, res_op 000, cin 0, dir 0, busy/load_en/step_en/done 0, including mid-SHIFT; no done pulse is produced for the aborted operation.
REQ-026 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL, with macro ALU_SEQ_ABORT_EN defined, add input abort (1 bit): abort=1 at an edge in LOAD or SHIFT forces IDLE next cycle with no done; abort has no effect in IDLE or DONE, and abort beats start in IDLE.
REQ-028 SHALL, without ALU_SEQ_ABORT_EN, have no abort port and no abort logic.

Verification
REQ-029 SHALL cover: R ADD (alu_op=01, funccode=00000) start -> load_en cycle k+1, done cycle k+2, res_op=000, no step_en.
REQ-030 SHALL cover: R right shift funccode=00110, shamt=5 -> load_en once, step_en exactly 5 cycles, dir=1, res_op=100, done cycle k+7.
REQ-031 SHALL cover: SHIFT_A funccode=01000, shamt=0 -> zero step_en cycles, done cycle k+2; shamt=31 -> 31 step_en cycles, done cycle k+33.
REQ-032 SHALL cover: start held high continuously for R XOR -> done pulses every 3 cycles, start ignored while busy=1, funccode change mid-op leaves res_op=011.
REQ-033 SHALL cover: rst=0 during SHIFT step 3 of 10 -> outputs zero asynchronously, no done; I-type funccode=00001 after release -> res_op=001, done cycle k+2.
REQ-034 SHALL cover, with ALU_SEQ_ABORT_EN: abort at SHIFT step 2 of 8 -> IDLE next cycle, no done, busy=0.
